// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake and queues them for IF/ID.
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch_cnt/flush_cnt performance counters.
module if_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h4421_0000
) (
    input  logic                     clk,
    input  logic                     Reset,
    output logic                     imem_req,
    output logic [31:0]              imem_addr,
    input  logic                     imem_ack,
    input  logic [31:0]              imem_rdata,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     stall,
    output logic                     inst_valid,
    output logic [31:0]              inst_out,
    output logic [31:0]              inst_pc,
    output logic [$clog2(DEPTH):0]   queue_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]              fetch_cnt,
    output logic [15:0]              flush_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic            r_en;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_req_addr;
    logic [31:0]     r_pc_q   [DEPTH];
    logic [31:0]     r_inst_q [DEPTH];
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    logic            w_req;
    logic [31:0]     w_addr;
    logic            w_push;
    logic            w_pop;
    logic            w_drop;
    logic            w_issue;
    logic            w_space;
    logic [31:0]     w_next_pc;
    logic            w_unused;

    assign w_space  = (r_count < CW'(DEPTH));
    assign w_unused = ^redirect_pc[1:0];

    // State register; r_en holds fetch off for the first cycle after reset release.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_en    <= 1'b1;
        end
    end

    // Next-state and memory handshake decode.
    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_addr       = r_fetch_pc;
        w_push       = 1'b0;
        w_drop       = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_en && !redirect_valid && w_space) begin
                    w_req = 1'b1;
                    if (imem_ack) begin
                        w_push = 1'b1;
                    end else begin
                        w_issue      = 1'b1;
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_req  = 1'b1;
                w_addr = r_req_addr;
                if (redirect_valid) begin
                    w_next_state = imem_ack ? S_IDLE : S_DRAIN;
                end else if (imem_ack) begin
                    w_push       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_DRAIN: begin
                w_req  = 1'b1;
                w_addr = r_req_addr;
                if (imem_ack) begin
                    w_drop       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_pop = inst_valid && !stall && !redirect_valid;

    always_comb begin
        w_next_pc = r_fetch_pc;
        if (redirect_valid) begin
            w_next_pc = {redirect_pc[31:2], 2'b00};
        end else if (w_push) begin
            w_next_pc = r_fetch_pc + 32'd4;
        end
    end

    // PC, outstanding-request address and queue pointers.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_fetch_pc <= w_next_pc;
            if (w_issue) begin
                r_req_addr <= r_fetch_pc;
            end
            if (redirect_valid) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CW'(1);
                    2'b01:   r_count <= r_count - CW'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage needs no reset; entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push && !redirect_valid) begin
            r_pc_q[r_wr_ptr]   <= r_fetch_pc;
            r_inst_q[r_wr_ptr] <= imem_rdata;
        end
    end

    assign imem_req    = w_req;
    assign imem_addr   = w_addr;
    assign inst_valid  = (r_count != '0);
    assign inst_out    = inst_valid ? r_inst_q[r_rd_ptr] : NOP_INST;
    assign inst_pc     = inst_valid ? r_pc_q[r_rd_ptr] : 32'h0;
    assign queue_count = r_count;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_flush_cnt;
    logic [16:0] w_flush_sum;

    assign w_flush_sum = 17'(r_flush_cnt)
                       + (redirect_valid ? 17'(r_count) : 17'd0)
                       + 17'(w_drop);

    // Saturating performance counters.
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_fetch_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_push && !redirect_valid && (r_fetch_cnt != 16'hFFFF)) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            r_flush_cnt <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
        end
    end

    assign fetch_cnt = r_fetch_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized bench for if_fetch_queue against a queue-based reference model of the fetch stage.
module tb_if_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h4421_0000;

    logic        clk;
    logic        Reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [$clog2(DEPTH):0] queue_count;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt;
    logic [15:0] flush_cnt;
`endif

    if_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC),
        .NOP_INST (NOP_INST)
    ) dut (
        .clk            (clk),
        .Reset          (Reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .inst_valid     (inst_valid),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .queue_count    (queue_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt      (fetch_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    // Reference model: what the fetch stage should hold, not how it is built.
    ent_t        mq[$];
    logic [31:0] m_pc;
    logic [31:0] m_pend_addr;
    bit          m_pend;
    bit          m_disc;
    bit          m_en;
    int          busy;
    int          mem_lat;
    int          n_tests;
    int          n_fail;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc   = RESET_PC;
        m_pend = 1'b0;
        m_disc = 1'b0;
        m_en   = 1'b0;
        busy   = 0;
    endtask

    task automatic check_head(input string tag);
        check({tag, "_valid"}, 32'(inst_valid), 32'(mq.size() > 0));
        check({tag, "_inst"},  inst_out, (mq.size() > 0) ? mq[0].inst : NOP_INST);
        check({tag, "_pc"},    inst_pc,  (mq.size() > 0) ? mq[0].pc : 32'h0);
        check({tag, "_count"}, 32'(queue_count), 32'(mq.size()));
    endtask

    // Assert reset mid-cycle, check reset outputs, present a stale ack around release.
    task automatic do_reset();
        Reset          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_ack       = 1'b0;
        imem_rdata     = 32'h0;
        #1;
        model_reset();
        check("rst_req",  32'(imem_req), 32'h0);
        check("rst_addr", imem_addr, RESET_PC);
        check_head("rst");
        @(posedge clk);
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        Reset      = 1'b1;
        @(posedge clk);
        m_en = 1'b1;
        #1;
        imem_ack = 1'b0;
    endtask

    // One clock cycle: drive, check at negedge, advance the model at posedge.
    task automatic step(input bit st, input bit rv, input logic [31:0] rpc);
        bit          e_req;
        bit          ack;
        logic [31:0] e_addr;
        ent_t        e;
        e_req  = m_pend || (m_en && !rv && (mq.size() < DEPTH));
        e_addr = m_pend ? m_pend_addr : m_pc;
        ack    = e_req && (busy >= mem_lat);
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_ack       = ack;
        imem_rdata     = ack ? mem_data(e_addr) : $urandom;
        @(negedge clk);
        check("req",  32'(imem_req), 32'(e_req));
        check("addr", imem_addr, e_addr);
        check_head("head");
        @(posedge clk);
        busy = (e_req && !ack) ? busy + 1 : 0;
        if (rv) begin
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
            if (m_pend && !ack) begin
                m_disc = 1'b1;
            end else begin
                m_pend = 1'b0;
                m_disc = 1'b0;
            end
        end else begin
            if (mq.size() > 0 && !st) void'(mq.pop_front());
            if (ack && !m_disc) begin
                e.pc   = e_addr;
                e.inst = mem_data(e_addr);
                mq.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            if (ack) begin
                m_pend = 1'b0;
                m_disc = 1'b0;
            end else if (e_req) begin
                m_pend      = 1'b1;
                m_pend_addr = e_addr;
            end
        end
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mem_lat = 0;
        do_reset();

        // Zero-wait streaming from reset.
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);

        // Stall held: queue fills, request drops, head frozen; then drains in order.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0);
        check("full_count", 32'(queue_count), 32'(DEPTH));
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0);

        // Redirect with three entries queued.
        for (int g = 0; g < 20 && mq.size() < 3; g++) step(1'b1, 1'b0, 32'h0);
        check("pre_redir_count", 32'(queue_count), 32'd3);
        step(1'b0, 1'b1, 32'h32);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

        // Slow memory: redirect while waiting on 0x8 must drain and drop that response.
        mem_lat = 3;
        step(1'b0, 1'b1, 32'h8);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h40);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        mem_lat = 0;
        step(1'b0, 1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0);

        // Reset while a request is outstanding.
        mem_lat = 3;
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        do_reset();
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) mem_lat = int'($urandom_range(0, 3));
            step(($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
Instruction-fetch stage sitting directly upstream of the IF/ID pipeline register. It owns the PC, issues word fetches to instruction memory over a req/ack handshake, and buffers the returned instructions in a small FIFO. It presents one instruction per cycle to IF/ID, honours downstream stall, and restarts fetch on a branch/jump redirect from ID. While empty or flushed it emits the pipeline's stall NOP.

Parameters:
DEPTH, 4, queue entries; power of 2, minimum 2.
RESET_PC, 32'h00000000, first fetch address after reset.
NOP_INST, 32'h44210000, bubble instruction: opcode 17, rs=1, rt=1, imm=0.

Ports:
clk  in  1  clock, rising edge.
Reset  in  1  asynchronous, active-low; Reset==0 resets the block.
imem_req  out  1  fetch request.
imem_addr  out  32  fetch address, word-aligned.
imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
imem_rdata  in  32  fetched instruction.
redirect_valid  in  1  branch/jump taken in ID.
redirect_pc  in  32  new fetch target.
stall  in  1  IF/ID cannot accept this cycle.
inst_valid  out  1  queue head valid.
inst_out  out  32  queue head instruction; NOP_INST when inst_valid=0.
inst_pc  out  32  PC of inst_out; 0 when inst_valid=0.
queue_count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async assert, sync-safe deassert): fetch_pc=RESET_PC; queue empty; FSM=IDLE; imem_req=0; imem_addr=RESET_PC; inst_valid=0; inst_out=NOP_INST; inst_pc=0; queue_count=0. Reset mid-request abandons the request; its ack is ignored.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE: if queue_count < DEPTH and no redirect -> imem_req=1, imem_addr=fetch_pc, go to WAIT. Ack in the same cycle is legal (zero-wait memory) and is handled as in WAIT.
- WAIT: imem_req stays 1 and imem_addr stays stable until imem_ack.
- On ack in WAIT: push {fetch_pc, imem_rdata}; fetch_pc += 4, wrapping 32'hFFFFFFFC -> 0. Back-to-back issue next cycle if space remains.
- Only one request is outstanding. A request issues only when count < DEPTH, so a push never overflows.
- Pop: occurs when inst_valid && !stall. Push and pop in the same cycle leave count unchanged. A push into an empty queue is visible at the output the next cycle; there is no bypass.
- Redirect, which has highest priority:
  - Queue flushed; count=0 and inst_valid=0 next cycle.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Any pop or push in the same cycle is discarded.
  - In WAIT without ack: go to DRAIN.
  - In WAIT with ack, or in IDLE: go to IDLE.
- DRAIN: imem_req stays 1 with the old address until ack; the returned data is dropped; then go to IDLE. A further redirect in DRAIN only updates fetch_pc.
- Latency, zero-wait memory: redirect at cycle t -> imem_req with the new pc at t+1 -> inst_valid with that instruction at t+2.
- Stall held: the queue fills to DEPTH, imem_req drops to 0 in IDLE, and the head stays stable.

Optional Feature:
FETCH_PERF_CNT_EN: adds output ports fetch_cnt[15:0] and flush_cnt[15:0], both reset to 0 and saturating at 16'hFFFF.
- fetch_cnt: +1 per accepted ack in WAIT.
- flush_cnt: + the number of entries discarded on redirect, plus 1 per response dropped in DRAIN.
Without the macro, these ports and counters do not exist.

Test Plan:
- Reset=0 then 1, zero-wait memory returning addr+0x100, stall=0 -> imem_addr 0,4,8,... on consecutive cycles; first inst_valid two cycles after Reset release with inst_out=0x100 and inst_pc=0.
- stall=1 held for 10 cycles, DEPTH=4 -> queue_count reaches 4, imem_req=0, inst_out/inst_pc frozen; release stall -> pops every cycle in PC order with no gaps.
- Redirect to 0x32 with 3 entries queued -> next cycle inst_valid=0, inst_out=0x44210000, count=0; next imem_addr=0x30.
- Memory with 3-cycle ack latency, redirect to 0x40 during WAIT on addr 0x8 -> req held at 0x8 until ack, data dropped, then imem_req at 0x40; no entry with inst_pc=0x8 appears.
- fetch_pc=0xFFFFFFFC -> next fetch address 0x00000000.
- Reset asserted while in WAIT -> imem_req=0 immediately; a late ack after release is not pushed; fetch restarts at RESET_PC.
